button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the board's LED flasher outputs.
- Takes one raw, asynchronous, bouncing pushbutton or switch and turns it into a synchronized, debounced level.
- Also produces single-cycle press, release and long-press events.
- One instance per board key; events feed shell control logic and LED status.

Parameters:
DEBOUNCE_CYCLES, 32'd50000, consecutive stable synchronized samples needed to accept a level change; must be >= 1.
LONG_CYCLES, 32'd25000000, consecutive pressed samples after the press is accepted before long_press fires; must be >= 1.
ACTIVE_LOW, 1'b1, 1 = button_in reads 0 when pressed (board keys); 0 = reads 1 when pressed.
REPEAT_CYCLES, 32'd5000000, auto-repeat period in samples; used only with BUTTON_REPEAT_EN.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
button_in  input  1  raw asynchronous button level.
button_state  output  1  debounced level, 1 = pressed.
press_pulse  output  1  one-cycle pulse when a press is accepted.
release_pulse  output  1  one-cycle pulse when a release is accepted.
long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
held  output  1  level; 1 from long_press until the release is accepted.
repeat_pulse  output  1  one-cycle auto-repeat pulse; constant 0 without BUTTON_REPEAT_EN.

Behaviour:
- Synchronizer:
  - Two flops on button_in, then polarity normalized per ACTIVE_LOW; the result is the sample, 1 = pressed.
  - On reset, both flops load the released level.
- Reset, applied on any cycle including mid-debounce or mid-hold:
  - State RELEASED, all counters 0, all outputs 0.
  - No release_pulse is generated by reset.
  - A button held through reset is detected as a fresh press after DEBOUNCE_CYCLES.
- All outputs are registered.
- States RELEASED, PRESS_WAIT, PRESSED, LONG, RELEASE_WAIT; transitions are evaluated each cycle on the current sample.
  - RELEASED: sample=1 -> PRESS_WAIT with deb_cnt=1. If DEBOUNCE_CYCLES=1, go directly to PRESSED with press_pulse.
  - PRESS_WAIT:
    - sample=0 -> RELEASED, deb_cnt=0, no pulse.
    - sample=1 -> deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_CYCLES -> PRESSED; press_pulse=1 for that one cycle; button_state=1; hold_cnt=0.
  - PRESSED:
    - sample=1 -> hold_cnt++; when hold_cnt reaches LONG_CYCLES -> LONG, long_press=1 for one cycle, held=1.
    - sample=0 -> RELEASE_WAIT, deb_cnt=1; hold_cnt frozen.
  - LONG:
    - sample=0 -> RELEASE_WAIT, deb_cnt=1.
    - sample=1 -> stay in LONG.
  - RELEASE_WAIT:
    - sample=1 -> return to PRESSED if held=0, or to LONG if held=1. No pulse; hold_cnt resumes from its frozen value.
    - sample=0 -> deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_CYCLES -> RELEASED; release_pulse=1 for one cycle; button_state=0; held=0.
    - button_state stays 1 throughout RELEASE_WAIT.
- Latency: if clock edge E is the first to capture a stable raw press, press_pulse is high in the cycle after edge E+1+DEBOUNCE_CYCLES. Release latency is symmetric.
- Counters:
  - 32-bit, compared for equality.
  - They never wrap, because every terminal count forces a transition that clears or freezes them.
- Pulse rules:
  - At most one of press_pulse, release_pulse, long_press, repeat_pulse is high in any cycle.
  - long_press never fires in the same cycle as press_pulse, since LONG_CYCLES >= 1.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- Defined:
  - In LONG, rep_cnt counts pressed samples; it starts at 0 in the cycle long_press fires.
  - When rep_cnt reaches REPEAT_CYCLES, repeat_pulse=1 for one cycle and rep_cnt resets to 0.
  - rep_cnt freezes in RELEASE_WAIT and clears on entry to RELEASED or on reset.
- Not defined: repeat_pulse is tied 0, no rep_cnt logic is built, and REPEAT_CYCLES is ignored.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0.
1. Clean press: button_in 0->1 before edge 0 and held -> press_pulse high only in the cycle after edge 5; button_state=1 from the same cycle.
2. Bounce: button_in toggles 1,0,1,1,0 across consecutive edges, then stays 0 -> no press_pulse; button_state stays 0; state returns to RELEASED.
3. Long hold: press held 30 cycles, then clean release -> press_pulse, then long_press 10 cycles later with held=1. After release, release_pulse 5 edges later (2 sync + 4 debounce, minus 1), with held=0 and button_state=0 in the same cycle.
4. Release glitch: pressed and accepted; one-cycle 0 glitch at hold_cnt=5 -> no release_pulse; long_press fires after 10 total pressed samples of hold_cnt.
5. Reset mid-hold: reset asserted for 1 cycle while in LONG with button held -> all outputs 0 after the edge, no release_pulse. A new press_pulse follows 6 edges after reset deasserts.
6. BUTTON_REPEAT_EN defined, hold held past long_press -> repeat_pulse at long_press+3, +6, +9...; no repeat_pulse after release is accepted. Same hold without the macro -> repeat_pulse constant 0.

Source files
------------

// File: rtl/button_debouncer.sv
// Two-flop synchronizer and debounce FSM for one board key: debounced level plus
// press, release, long-press and held outputs. Define BUTTON_REPEAT_EN for auto-repeat.
module button_debouncer #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd50000,
    parameter logic [31:0] LONG_CYCLES     = 32'd25000000,
    parameter logic        ACTIVE_LOW      = 1'b1,
    parameter logic [31:0] REPEAT_CYCLES   = 32'd5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic held,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        LONG,
        RELEASE_WAIT
    } state_t;

    state_t      state, state_n;
    logic        sync_meta;
    logic        sync_out;
    logic        sample;
    logic [31:0] deb_cnt, deb_n;
    logic [31:0] hold_cnt, hold_n;
    logic [31:0] deb_inc;
    logic [31:0] hold_inc;
    logic        state_lvl_n;
    logic        held_n;
    logic        press_n;
    logic        release_n;
    logic        long_n;
    logic        rel_go;

    // Pressed reads as 1 regardless of board wiring polarity.
    assign sample   = sync_out ^ ACTIVE_LOW;
    assign deb_inc  = deb_cnt + 32'd1;
    assign hold_inc = hold_cnt + 32'd1;

`ifdef BUTTON_REPEAT_EN
    logic [31:0] rep_cnt, rep_n;
    logic [31:0] rep_inc;
    logic        repeat_n;

    assign rep_inc = rep_cnt + 32'd1;
`else
    logic unused_repeat;

    assign unused_repeat = ^REPEAT_CYCLES;
    assign repeat_pulse  = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        deb_n       = deb_cnt;
        hold_n      = hold_cnt;
        state_lvl_n = button_state;
        held_n      = held;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        rel_go      = 1'b0;
`ifdef BUTTON_REPEAT_EN
        rep_n       = rep_cnt;
        repeat_n    = 1'b0;
`endif
        unique case (state)
            RELEASED: begin
                if (sample) begin
                    if (DEBOUNCE_CYCLES == 32'd1) begin
                        state_n     = PRESSED;
                        press_n     = 1'b1;
                        state_lvl_n = 1'b1;
                        hold_n      = 32'd0;
                        deb_n       = 32'd0;
                    end else begin
                        state_n = PRESS_WAIT;
                        deb_n   = 32'd1;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_n = RELEASED;
                    deb_n   = 32'd0;
                end else if (deb_inc == DEBOUNCE_CYCLES) begin
                    state_n     = PRESSED;
                    press_n     = 1'b1;
                    state_lvl_n = 1'b1;
                    hold_n      = 32'd0;
                    deb_n       = 32'd0;
                end else begin
                    deb_n = deb_inc;
                end
            end
            PRESSED: begin
                if (sample) begin
                    hold_n = hold_inc;
                    if (hold_inc == LONG_CYCLES) begin
                        state_n = LONG;
                        long_n  = 1'b1;
                        held_n  = 1'b1;
`ifdef BUTTON_REPEAT_EN
                        rep_n   = 32'd0;
`endif
                    end
                end else if (DEBOUNCE_CYCLES == 32'd1) begin
                    rel_go = 1'b1;
                end else begin
                    state_n = RELEASE_WAIT;
                    deb_n   = 32'd1;
                end
            end
            LONG: begin
                if (sample) begin
`ifdef BUTTON_REPEAT_EN
                    if (rep_inc == REPEAT_CYCLES) begin
                        repeat_n = 1'b1;
                        rep_n    = 32'd0;
                    end else begin
                        rep_n = rep_inc;
                    end
`endif
                end else if (DEBOUNCE_CYCLES == 32'd1) begin
                    rel_go = 1'b1;
                end else begin
                    state_n = RELEASE_WAIT;
                    deb_n   = 32'd1;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes the hold where it left off.
                if (sample) begin
                    state_n = held ? LONG : PRESSED;
                    deb_n   = 32'd0;
                end else if (deb_inc == DEBOUNCE_CYCLES) begin
                    rel_go = 1'b1;
                end else begin
                    deb_n = deb_inc;
                end
            end
            default: begin
                state_n = RELEASED;
            end
        endcase

        if (rel_go) begin
            state_n     = RELEASED;
            release_n   = 1'b1;
            state_lvl_n = 1'b0;
            held_n      = 1'b0;
            deb_n       = 32'd0;
            hold_n      = 32'd0;
`ifdef BUTTON_REPEAT_EN
            rep_n       = 32'd0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta     <= ACTIVE_LOW;
            sync_out      <= ACTIVE_LOW;
            state         <= RELEASED;
            deb_cnt       <= 32'd0;
            hold_cnt      <= 32'd0;
            button_state  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            sync_meta     <= button_in;
            sync_out      <= sync_meta;
            state         <= state_n;
            deb_cnt       <= deb_n;
            hold_cnt      <= hold_n;
            button_state  <= state_lvl_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_press    <= long_n;
            held          <= held_n;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt      <= 32'd0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_n;
            repeat_pulse <= repeat_n;
        end
    end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: DEBOUNCE=4, LONG=10, REPEAT=3, active-high key.
// Expected edge numbers are hand-derived from the 2-flop sync plus debounce count.
module tb_button_debouncer;

    logic clock;
    logic reset;
    logic button_in;
    logic button_state;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic held;
    logic repeat_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;
    int press_cnt, press_at;
    int rel_cnt, rel_at, rel_held, rel_bs;
    int long_cnt, long_at, long_held;
    int rep_cnt, rep_first, rep_last;
    int multi_cnt = 0;
    int e0, r0;

`ifdef BUTTON_REPEAT_EN
    localparam int EXP_REP = 5;
`else
    localparam int EXP_REP = 0;
`endif

    button_debouncer #(
        .DEBOUNCE_CYCLES(32'd4),
        .LONG_CYCLES    (32'd10),
        .ACTIVE_LOW     (1'b0),
        .REPEAT_CYCLES  (32'd3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .button_state (button_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .held         (held),
        .repeat_pulse (repeat_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        int n;
        @(posedge clock);
        #1;
        edge_no++;
        if (press_pulse) begin
            press_cnt++;
            press_at = edge_no;
        end
        if (release_pulse) begin
            rel_cnt++;
            rel_at   = edge_no;
            rel_held = int'(held);
            rel_bs   = int'(button_state);
        end
        if (long_press) begin
            long_cnt++;
            long_at   = edge_no;
            long_held = int'(held);
        end
        if (repeat_pulse) begin
            rep_cnt++;
            if (rep_cnt == 1) rep_first = edge_no;
            rep_last = edge_no;
        end
        n = int'(press_pulse) + int'(release_pulse) + int'(long_press)
          + int'(repeat_pulse);
        if (n > 1) multi_cnt++;
    endtask

    task automatic clear_stats();
        press_cnt = 0; press_at  = -1;
        rel_cnt   = 0; rel_at    = -1; rel_held = -1; rel_bs = -1;
        long_cnt  = 0; long_at   = -1; long_held = -1;
        rep_cnt   = 0; rep_first = -1; rep_last = -1;
    endtask

    task automatic do_reset();
        button_in = 1'b0;
        reset     = 1'b1;
        tick();
        check("reset_outputs",
              {26'd0, button_state, press_pulse, release_pulse,
               long_press, held, repeat_pulse}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        clear_stats();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        button_in = 1'b0;
        clear_stats();

        // Clean press and clean release.
        do_reset();
        button_in = 1'b1;
        e0 = edge_no + 1;
        repeat (5) tick();
        check("t1_state_before", button_state, 0);
        check("t1_no_early_press", press_cnt, 0);
        tick();
        check("t1_press_pulse", press_pulse, 1);
        check("t1_state_after", button_state, 1);
        check("t1_press_at", press_at, e0 + 5);
        tick();
        check("t1_pulse_width", press_pulse, 0);
        button_in = 1'b0;
        r0 = edge_no + 1;
        repeat (8) tick();
        check("t1_release_at", rel_at, r0 + 5);
        check("t1_state_released", button_state, 0);

        // Bounce never accepted, then a clean press from a fresh count.
        do_reset();
        foreach (e0_bits[i]) begin
            button_in = e0_bits[i];
            tick();
        end
        button_in = 1'b0;
        repeat (10) tick();
        check("t2_no_press", press_cnt, 0);
        check("t2_state", button_state, 0);
        button_in = 1'b1;
        e0 = edge_no + 1;
        repeat (8) tick();
        check("t2_fresh_press_at", press_at, e0 + 5);

        // Long hold, auto-repeat when built, then release.
        do_reset();
        button_in = 1'b1;
        e0 = edge_no + 1;
        repeat (30) tick();
        check("t3_held_level", held, 1);
        button_in = 1'b0;
        r0 = edge_no + 1;
        repeat (8) tick();
        check("t3_press_at", press_at, e0 + 5);
        check("t3_long_at", long_at, e0 + 15);
        check("t3_long_cnt", long_cnt, 1);
        check("t3_long_held", long_held, 1);
        check("t3_release_at", rel_at, r0 + 5);
        check("t3_release_held", rel_held, 0);
        check("t3_release_state", rel_bs, 0);
        check("t3_repeat_cnt", rep_cnt, EXP_REP);
`ifdef BUTTON_REPEAT_EN
        check("t3_repeat_first", rep_first, e0 + 18);
        check("t3_repeat_last", rep_last, e0 + 30);
`endif

        // One-sample release glitch at hold_cnt=5 delays long_press by 2 edges.
        do_reset();
        button_in = 1'b1;
        e0 = edge_no + 1;
        repeat (9) tick();
        button_in = 1'b0;
        tick();
        button_in = 1'b1;
        repeat (11) tick();
        check("t4_no_release", rel_cnt, 0);
        check("t4_long_at", long_at, e0 + 17);
        check("t4_long_cnt", long_cnt, 1);
        check("t4_state", button_state, 1);
        check("t4_held", held, 1);

        // Reset while in LONG with the key still down.
        clear_stats();
        reset = 1'b1;
        tick();
        check("t5_reset_outputs",
              {26'd0, button_state, press_pulse, release_pulse,
               long_press, held, repeat_pulse}, 32'd0);
        r0 = edge_no;
        reset = 1'b0;
        repeat (8) tick();
        check("t5_no_release", rel_cnt, 0);
        check("t5_repress_at", press_at, r0 + 6);
        check("t5_state", button_state, 1);

        check("pulse_onehot", multi_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    logic e0_bits [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

endmodule
